// File: rtl/serdes_64b66b_tx_sched_if.sv
// Requester word streams and encoder-facing word bus of the 64B/66B TX frame scheduler.
// The slave modport is the scheduler. The master modport is the requester/encoder side.
interface serdes_64b66b_tx_sched_if;
  logic        I_req0_valid;
  logic [63:0] I_req0_data;
  logic        I_req0_last;
  logic        O_req0_ready;
  logic        I_req1_valid;
  logic [63:0] I_req1_data;
  logic        I_req1_last;
  logic        O_req1_ready;
  logic [63:0] O_tx_data;
  logic [7:0]  O_tx_ctrl;

  modport master (
    output I_req0_valid, I_req0_data, I_req0_last,
    output I_req1_valid, I_req1_data, I_req1_last,
    input  O_req0_ready, O_req1_ready, O_tx_data, O_tx_ctrl
  );

  modport slave (
    input  I_req0_valid, I_req0_data, I_req0_last,
    input  I_req1_valid, I_req1_data, I_req1_last,
    output O_req0_ready, O_req1_ready, O_tx_data, O_tx_ctrl
  );
endinterface

// File: rtl/serdes_64b66b_tx_sched.sv
// Round-robin frame scheduler for the 64B/66B TX encoder: wraps requester frames as S/D.../T,
// inserts filler frames when idle, caps frame length and counts underruns/truncations/fillers.
module serdes_64b66b_tx_sched #(
  parameter int MAX_D_WORDS = 16
) (
  input  logic                     I_pcs_tx_clk,
  input  logic                     I_pcs_tx_rst,
  serdes_64b66b_tx_sched_if.slave  bus,
  output logic [7:0]               O_underrun_cnt,
  output logic [7:0]               O_trunc_cnt,
  output logic [15:0]              O_filler_cnt
);
  localparam int DATA_W = 64;

  localparam logic [7:0]        CTRL_S = 8'h01;
  localparam logic [7:0]        CTRL_D = 8'h00;
  localparam logic [7:0]        CTRL_T = 8'h80;
  localparam logic [7:0]        CTRL_RST = 8'hFF;
  localparam logic [DATA_W-1:0] DATA_S = {56'd0, 8'hFB};
  localparam logic [DATA_W-1:0] DATA_T = {8'hFD, 56'd0};

  typedef enum logic [1:0] {ST_START, ST_DATA, ST_TERM} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              filler_q, filler_d;
  logic              last_srv_q, last_srv_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [1:0]        flush_q, flush_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [7:0]        tx_ctrl_q, tx_ctrl_d;
  logic [7:0]        underrun_q, underrun_d;
  logic [7:0]        trunc_q, trunc_d;
  logic [15:0]       filler_cnt_q, filler_cnt_d;

  logic [1:0]        vld, lst, rdy, elig;
  logic [DATA_W-1:0] gdata;
  logic [8:0]        dcnt_nxt;
  logic              at_max;

  assign vld   = {bus.I_req1_valid, bus.I_req0_valid};
  assign lst   = {bus.I_req1_last, bus.I_req0_last};
  assign gdata = grant_q ? bus.I_req1_data : bus.I_req0_data;
  assign elig  = vld & ~flush_q;

  // A flushing requester keeps ready high in every state; it can never also hold the grant.
  assign rdy[0] = flush_q[0] | ((state_q == ST_DATA) && !filler_q && !grant_q);
  assign rdy[1] = flush_q[1] | ((state_q == ST_DATA) && !filler_q && grant_q);

  assign dcnt_nxt = {1'b0, dcnt_q} + 9'd1;
  assign at_max   = (dcnt_nxt == 9'(MAX_D_WORDS));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    filler_d     = filler_q;
    last_srv_d   = last_srv_q;
    dcnt_d       = dcnt_q;
    flush_d      = flush_q;
    tx_data_d    = '0;
    tx_ctrl_d    = CTRL_D;
    underrun_d   = underrun_q;
    trunc_d      = trunc_q;
    filler_cnt_d = filler_cnt_q;

    for (int n = 0; n < 2; n++) begin
      if (flush_q[n] && vld[n] && lst[n]) flush_d[n] = 1'b0;
    end

    case (state_q)
      ST_START: begin
        tx_ctrl_d = CTRL_S;
        tx_data_d = DATA_S;
        dcnt_d    = '0;
        state_d   = ST_DATA;
        filler_d  = 1'b0;
        if (elig == 2'b11) begin
          grant_d    = ~last_srv_q;
          last_srv_d = ~last_srv_q;
        end else if (elig[0]) begin
          grant_d    = 1'b0;
          last_srv_d = 1'b0;
        end else if (elig[1]) begin
          grant_d    = 1'b1;
          last_srv_d = 1'b1;
        end else begin
          filler_d     = 1'b1;
          filler_cnt_d = filler_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        tx_ctrl_d = CTRL_D;
        if (filler_q) begin
          state_d = ST_TERM;
        end else begin
          dcnt_d = dcnt_nxt[7:0];
          if (vld[grant_q]) begin
            tx_data_d = gdata;
          end else begin
            underrun_d = sat_inc8(underrun_q);
          end
          // Cutting a frame short (even on a padded word) discards the requester's remaining words.
          if (vld[grant_q] && lst[grant_q]) begin
            state_d = ST_TERM;
          end else if (at_max) begin
            state_d          = ST_TERM;
            trunc_d          = sat_inc8(trunc_q);
            flush_d[grant_q] = 1'b1;
          end
        end
      end
      ST_TERM: begin
        tx_ctrl_d = CTRL_T;
        tx_data_d = DATA_T;
        state_d   = ST_START;
      end
      default: begin
        tx_ctrl_d = CTRL_RST;
        state_d   = ST_START;
      end
    endcase
  end

  always_ff @(posedge I_pcs_tx_clk or posedge I_pcs_tx_rst) begin
    if (I_pcs_tx_rst) begin
      state_q      <= ST_START;
      grant_q      <= 1'b0;
      filler_q     <= 1'b0;
      last_srv_q   <= 1'b1;
      dcnt_q       <= '0;
      flush_q      <= '0;
      tx_data_q    <= '0;
      tx_ctrl_q    <= CTRL_RST;
      underrun_q   <= '0;
      trunc_q      <= '0;
      filler_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      filler_q     <= filler_d;
      last_srv_q   <= last_srv_d;
      dcnt_q       <= dcnt_d;
      flush_q      <= flush_d;
      tx_data_q    <= tx_data_d;
      tx_ctrl_q    <= tx_ctrl_d;
      underrun_q   <= underrun_d;
      trunc_q      <= trunc_d;
      filler_cnt_q <= filler_cnt_d;
    end
  end

  assign bus.O_req0_ready = rdy[0];
  assign bus.O_req1_ready = rdy[1];
  assign bus.O_tx_data    = tx_data_q;
  assign bus.O_tx_ctrl    = tx_ctrl_q;
  assign O_underrun_cnt   = underrun_q;
  assign O_trunc_cnt      = trunc_q;
  assign O_filler_cnt     = filler_cnt_q;
endmodule
